// File: rtl/std_sram_singleport_rwctrl.sv
// Read/write request controller for a single-port SRAM whose read data
// passes through an output register (DFF on output). Reads are issued in
// request order, the SRAM is kept reading for one extra cycle so the output
// register captures the data, and read data is buffered in a 4-entry FIFO.
// The FIFO is protected by credits, so back-pressure on rsp_ready never
// loses data.
//
// Handshake semantics (both channels): a transfer happens in a cycle where
// valid=1 and ready=1 are sampled on the same rising clk edge. A producer
// holding valid=1 keeps its payload stable until the transfer. req_ready
// depends on req_we and on registered state only. It never depends on
// rsp_ready.
module std_sram_singleport_rwctrl #(
   parameter int ADDR_WIDTH = 1,
   parameter int DATA_WIDTH = 1
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  req_valid,
   output logic                  req_ready,
   input  logic                  req_we,
   input  logic [ADDR_WIDTH-1:0] req_addr,
   input  logic [DATA_WIDTH-1:0] req_wdata,
   output logic                  rsp_valid,
   input  logic                  rsp_ready,
   output logic [DATA_WIDTH-1:0] rsp_rdata,
   output logic                  sram_regrst,
   output logic                  sram_en,
   output logic                  sram_we,
   output logic [ADDR_WIDTH-1:0] sram_addr,
   output logic [DATA_WIDTH-1:0] sram_din,
   input  logic [DATA_WIDTH-1:0] sram_dout
);

   localparam int DEPTH = 4;

   // Read pipeline: rd_s1 = a read was issued last cycle,
   // rd_s2 = a read was issued two cycles ago (its data is on sram_dout now).
   logic                  rd_s1;
   logic                  rd_s2;
   logic [ADDR_WIDTH-1:0] rd_addr_q;

   // Response FIFO
   logic [DATA_WIDTH-1:0] fifo_mem [DEPTH];
   logic [1:0]            wr_ptr;
   logic [1:0]            rd_ptr;
   logic [2:0]            count;

   logic [2:0]            pending;
   logic                  credit_ok;
   logic                  accept;
   logic                  rd_accept;
   logic                  hold;
   logic                  push;
   logic                  pop;

   assign sram_regrst = reset;

   // Credit check: buffered entries plus reads still in the SRAM pipeline,
   // taken from registers only so the consumer side cannot reach req_ready.
   always_comb begin
      pending   = count + {2'b00, rd_s1} + {2'b00, rd_s2};
      credit_ok = (pending < 3'd4);
   end

   // Request acceptance: a write is refused in the cycle after a read issue
   // because that cycle must keep the SRAM reading. A read needs a free credit.
   always_comb begin
      req_ready = 1'b0;
      if (!reset) begin
         if (req_we) req_ready = ~rd_s1;
         else        req_ready = credit_ok;
      end
      accept    = req_valid & req_ready;
      rd_accept = accept & ~req_we;
      hold      = ~reset & rd_s1 & ~accept;
   end

   // SRAM drive: pass an accepted request straight through. Otherwise,
   // re-issue the previous read address so the output register loads.
   always_comb begin
      sram_en   = 1'b0;
      sram_we   = 1'b0;
      sram_addr = '0;
      sram_din  = '0;
      if (accept) begin
         sram_en   = 1'b1;
         sram_we   = req_we;
         sram_addr = req_addr;
         sram_din  = req_wdata;
      end else if (hold) begin
         sram_en   = 1'b1;
         sram_we   = 1'b0;
         sram_addr = rd_addr_q;
      end
   end

   // FIFO push/pop strobes and output view
   always_comb begin
      push      = rd_s2;
      rsp_valid = (count != 3'd0);
      pop       = rsp_valid & rsp_ready;
      rsp_rdata = fifo_mem[rd_ptr];
   end

   // Read pipeline tracking. Reset discards every read in flight.
   always_ff @(posedge clk) begin
      if (reset) begin
         rd_s1 <= 1'b0;
         rd_s2 <= 1'b0;
      end else begin
         rd_s1 <= rd_accept;
         rd_s2 <= rd_s1;
      end
   end

   // Remember the last read address for the hold cycle
   always_ff @(posedge clk) begin
      if (reset)          rd_addr_q <= '0;
      else if (rd_accept) rd_addr_q <= req_addr;
   end

   // FIFO pointers and occupancy. Pointers wrap modulo 4.
   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr <= 2'd0;
         rd_ptr <= 2'd0;
         count  <= 3'd0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 2'd1;
         if (pop)  rd_ptr <= rd_ptr + 2'd1;
         case ({push, pop})
            2'b10:   count <= count + 3'd1;
            2'b01:   count <= count - 3'd1;
            default: count <= count;
         endcase
      end
   end

   // FIFO storage: capture registered SRAM data two cycles after issue
   always_ff @(posedge clk) begin
      if (!reset && push) fifo_mem[wr_ptr] <= sram_dout;
   end

endmodule
